fg_prog_sequencer: RTL and testbench

Digital sequencer for floating-gate programming of an island's switch matrices and CAB devices. It accepts programming commands over a valid/ready interface and drives the programming mux with break-before-make ordering and cycle-counted pulse widths. The programming mux consists of the horizontal and vertical `VinjDecode2to4` decoders, `drainSelect`, the `4TGate` drain-cutoff prog/run switches, and the VTUN enable. One instance sits between the host register interface and the island programming periphery.

---
 rtl/fg_prog_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer.sv
// ---------------------------------------------------------------------------
// fg_prog_sequencer
//
// Sequences floating-gate programming of one island's switch matrices and
// CAB devices. Commands arrive over a valid/ready handshake. The block drives
// the programming mux:
//   - island/row/column decoder addresses
//   - drain-cutoff prog/run switches, with break-before-make ordering
//   - drain select
//   - injection pulse
//   - tunnelling enable
// Pulse widths are counted in clock cycles.
//
// Optional feature: define FG_PROG_ABORT_EN to add the 'abort' input. Abort
// ends an active SETUP/PULSE/GAP/TUN phase early and reports done+err
// together.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake
//   cmd_op            : 00 INJECT, 01 TUNNEL, 10 RUN_MODE, 11 PROG_MODE
//   cmd_island/row/col: target island / vertical / horizontal address
//   cmd_width         : pulse length in cycles
//   cmd_reps          : INJECT pulse count
//   abort             : (FG_PROG_ABORT_EN only) early termination request
//   isl_sel, row_addr, col_addr, dec_en : decoder drive
//   prog, run         : drain-cutoff switches
//   drain_sel         : drain select to programming drain
//   vinj_pulse        : injection pulse
//   vtun_en           : tunnelling enable
//   busy              : FSM not in IDLE
//   done              : one-cycle completion pulse
//   err               : one-cycle reject/abort pulse
// All outputs are registered.
// ---------------------------------------------------------------------------
module fg_prog_sequencer #(
    parameter int ISL_BITS   = 2,
    parameter int ROW_BITS   = 6,
    parameter int COL_BITS   = 6,
    parameter int NUM_ROWS   = 12,
    parameter int NUM_COLS   = 26,
    parameter int PW_BITS    = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ISL_BITS-1:0] cmd_island,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [PW_BITS-1:0]  cmd_width,
    input  logic [7:0]          cmd_reps,
`ifdef FG_PROG_ABORT_EN
    input  logic                abort,
`endif
    output logic [ISL_BITS-1:0] isl_sel,
    output logic [ROW_BITS-1:0] row_addr,
    output logic [COL_BITS-1:0] col_addr,
    output logic                dec_en,
    output logic                prog,
    output logic                run,
    output logic                drain_sel,
    output logic                vinj_pulse,
    output logic                vtun_en,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHECK    = 4'd1,
        ST_SETUP    = 4'd2,
        ST_PULSE    = 4'd3,
        ST_GAP      = 4'd4,
        ST_TUN      = 4'd5,
        ST_MODE_BRK = 4'd6,
        ST_MODE_MK  = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    localparam logic [1:0] OP_INJECT = 2'b00;
    localparam logic [1:0] OP_TUNNEL = 2'b01;

    // Counter reload for settle phases; SETTLE_CYC must fit in PW_BITS.
    localparam logic [PW_BITS-1:0]  SETTLE_M1 = PW_BITS'(SETTLE_CYC - 1);
    // One extra bit so a limit equal to 2^BITS still compares correctly.
    localparam logic [ROW_BITS:0]   ROW_LIM   = (ROW_BITS + 1)'(NUM_ROWS);
    localparam logic [COL_BITS:0]   COL_LIM   = (COL_BITS + 1)'(NUM_COLS);

    state_t                state_q, state_d;
    logic [PW_BITS-1:0]    cnt_q, cnt_d;
    logic [7:0]            rep_q, rep_d;
    logic                  mode_q, mode_d;        // 1 = PROG, 0 = RUN
    logic                  aborted_q, aborted_d;

    // Latched command
    logic [1:0]            c_op_q, c_op_d;
    logic [ISL_BITS-1:0]   c_isl_q, c_isl_d;
    logic [ROW_BITS-1:0]   c_row_q, c_row_d;
    logic [COL_BITS-1:0]   c_col_q, c_col_d;
    logic [PW_BITS-1:0]    c_width_q, c_width_d;
    logic [7:0]            c_reps_q, c_reps_d;

    // Output registers
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ISL_BITS-1:0]   isl_sel_q, isl_sel_d;
    logic [ROW_BITS-1:0]   row_addr_q, row_addr_d;
    logic [COL_BITS-1:0]   col_addr_q, col_addr_d;
    logic                  dec_en_q, dec_en_d;
    logic                  prog_q, prog_d;
    logic                  run_q, run_d;
    logic                  drain_sel_q, drain_sel_d;
    logic                  vinj_q, vinj_d;
    logic                  vtun_q, vtun_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  abort_s;
    logic                  reject_s;
    logic                  want_prog_s;

`ifdef FG_PROG_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Legality check of the latched command, evaluated while in CHECK.
    always_comb begin
        reject_s = 1'b0;
        if (c_op_q == OP_INJECT) begin
            reject_s = ({1'b0, c_row_q} >= ROW_LIM) || ({1'b0, c_col_q} >= COL_LIM) ||
                       (c_reps_q == 8'd0) || (c_width_q == '0) || !mode_q;
        end else if (c_op_q == OP_TUNNEL) begin
            reject_s = (c_width_q == '0) || !mode_q;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Mode commands carry the target mode in op bit 0 (11 = PROG_MODE).
    assign want_prog_s = c_op_q[0];

    // Next-state, counters, command latch and mode flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        mode_d    = mode_q;
        aborted_d = aborted_q;
        c_op_d    = c_op_q;
        c_isl_d   = c_isl_q;
        c_row_d   = c_row_q;
        c_col_d   = c_col_q;
        c_width_d = c_width_q;
        c_reps_d  = c_reps_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is high whenever the FSM sits in IDLE.
                if (cmd_valid) begin
                    c_op_d    = cmd_op;
                    c_isl_d   = cmd_island;
                    c_row_d   = cmd_row;
                    c_col_d   = cmd_col;
                    c_width_d = cmd_width;
                    c_reps_d  = cmd_reps;
                    state_d   = ST_CHECK;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (reject_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (c_op_q == OP_INJECT) begin
                    cnt_d   = SETTLE_M1;
                    rep_d   = c_reps_q;
                    state_d = ST_SETUP;
                end else if (c_op_q == OP_TUNNEL) begin
                    cnt_d   = c_width_q - 1'b1;
                    state_d = ST_TUN;
                end else if (want_prog_s == mode_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = SETTLE_M1;
                    state_d = ST_MODE_BRK;
                end
            end
            ST_SETUP: begin
                if (abort_s) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == '0) begin
                    cnt_d   = c_width_q - 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (abort_s) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == '0) begin
                    cnt_d   = SETTLE_M1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                // Every pulse, including the last, is followed by a full gap.
                if (abort_s) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                end else if (rep_q == 8'd1) begin
                    state_d = ST_DONE;
                end else begin
                    rep_d   = rep_q - 8'd1;
                    cnt_d   = c_width_q - 1'b1;
                    state_d = ST_PULSE;
                end
            end
            ST_TUN: begin
                if (abort_s) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_MODE_BRK: begin
                if (cnt_q == '0) begin
                    mode_d  = want_prog_s;
                    state_d = ST_MODE_MK;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_MODE_MK: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                aborted_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so registered outputs line
    // up with the state they belong to.
    always_comb begin
        isl_sel_d   = '0;
        row_addr_d  = '0;
        col_addr_d  = '0;
        dec_en_d    = 1'b0;
        drain_sel_d = 1'b0;
        vinj_d      = 1'b0;
        vtun_d      = 1'b0;

        case (state_d)
            ST_SETUP, ST_GAP: begin
                isl_sel_d  = c_isl_q;
                row_addr_d = c_row_q;
                col_addr_d = c_col_q;
                dec_en_d   = 1'b1;
            end
            ST_PULSE: begin
                isl_sel_d   = c_isl_q;
                row_addr_d  = c_row_q;
                col_addr_d  = c_col_q;
                dec_en_d    = 1'b1;
                drain_sel_d = 1'b1;
                vinj_d      = 1'b1;
            end
            ST_TUN: begin
                // Tunnelling targets a whole island: island select only.
                isl_sel_d = c_isl_q;
                vtun_d    = 1'b1;
            end
            default: begin
                isl_sel_d = '0;
            end
        endcase

        // Both drain-cutoff switches open during the break phase.
        if (state_d == ST_MODE_BRK) begin
            prog_d = 1'b0;
            run_d  = 1'b0;
        end else begin
            prog_d = mode_d;
            run_d  = !mode_d;
        end

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State, counters, command latch and mode flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rep_q     <= 8'd0;
            mode_q    <= 1'b0;
            aborted_q <= 1'b0;
            c_op_q    <= 2'b00;
            c_isl_q   <= '0;
            c_row_q   <= '0;
            c_col_q   <= '0;
            c_width_q <= '0;
            c_reps_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            mode_q    <= mode_d;
            aborted_q <= aborted_d;
            c_op_q    <= c_op_d;
            c_isl_q   <= c_isl_d;
            c_row_q   <= c_row_d;
            c_col_q   <= c_col_d;
            c_width_q <= c_width_d;
            c_reps_q  <= c_reps_d;
        end
    end

    // Registered outputs; reset drops pulses immediately and selects run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b1;
            isl_sel_q   <= '0;
            row_addr_q  <= '0;
            col_addr_q  <= '0;
            dec_en_q    <= 1'b0;
            prog_q      <= 1'b0;
            run_q       <= 1'b1;
            drain_sel_q <= 1'b0;
            vinj_q      <= 1'b0;
            vtun_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            isl_sel_q   <= isl_sel_d;
            row_addr_q  <= row_addr_d;
            col_addr_q  <= col_addr_d;
            dec_en_q    <= dec_en_d;
            prog_q      <= prog_d;
            run_q       <= run_d;
            drain_sel_q <= drain_sel_d;
            vinj_q      <= vinj_d;
            vtun_q      <= vtun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            // An aborted run reports err alongside done.
            err_q       <= err_d || ((state_d == ST_DONE) && aborted_d);
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign isl_sel    = isl_sel_q;
    assign row_addr   = row_addr_q;
    assign col_addr   = col_addr_q;
    assign dec_en     = dec_en_q;
    assign prog       = prog_q;
    assign run        = run_q;
    assign drain_sel  = drain_sel_q;
    assign vinj_pulse = vinj_q;
    assign vtun_en    = vtun_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed self-checking bench for fg_prog_sequencer (default parameters,
// SETTLE_CYC = 4). Offsets are in cycles relative to the accept cycle T.
module tb_fg_prog_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_island;
    logic [5:0]  cmd_row;
    logic [5:0]  cmd_col;
    logic [15:0] cmd_width;
    logic [7:0]  cmd_reps;
    logic [1:0]  isl_sel;
    logic [5:0]  row_addr;
    logic [5:0]  col_addr;
    logic        dec_en, prog, run, drain_sel, vinj_pulse, vtun_en, busy, done, err;
`ifdef FG_PROG_ABORT_EN
    logic        abort;
`endif

    int n_cmp;
    int n_mis;

    // Per-command observation results
    int done_at, err_at, ready_at, run_fall_at, run_rise_at, prog_rise_at;
    int vinj_first, vinj_last, vinj_hi, vinj_rise, vtun_first, vtun_hi;
    int dec_hi, brk_cnt, bad, done_cnt, err_cnt, row_seen, col_seen;

    fg_prog_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_island (cmd_island),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_width  (cmd_width),
        .cmd_reps   (cmd_reps),
`ifdef FG_PROG_ABORT_EN
        .abort      (abort),
`endif
        .isl_sel    (isl_sel),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .dec_en     (dec_en),
        .prog       (prog),
        .run        (run),
        .drain_sel  (drain_sel),
        .vinj_pulse (vinj_pulse),
        .vtun_en    (vtun_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a command in cycle T; returns at the negedge of T+1 (CHECK).
    task automatic issue(input logic [1:0] op, input logic [5:0] row, input logic [5:0] col,
                         input logic [15:0] width, input logic [7:0] reps);
        @(negedge clk);
        cmd_op = op; cmd_island = 2'd2; cmd_row = row; cmd_col = col;
        cmd_width = width; cmd_reps = reps; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Sample outputs at negedges of T+1..T+n. If poke > 0, cmd_valid is
    // raised for two cycles starting at T+poke.
    task automatic watch(input int n, input int poke);
        logic pv, pr, pp;
        done_at = -1; err_at = -1; ready_at = -1; run_fall_at = -1; run_rise_at = -1;
        prog_rise_at = -1; vinj_first = -1; vinj_last = -1; vinj_hi = 0; vinj_rise = 0;
        vtun_first = -1; vtun_hi = 0; dec_hi = 0; brk_cnt = 0; bad = 0; done_cnt = 0;
        err_cnt = 0; row_seen = -1; col_seen = -1;
        pv = vinj_pulse; pr = run; pp = prog;
        for (int i = 1; i <= n; i++) begin
            if (vinj_pulse) begin
                vinj_hi++;
                if (vinj_first < 0) begin
                    vinj_first = i; row_seen = int'(row_addr); col_seen = int'(col_addr);
                end
                vinj_last = i;
                if (!pv) vinj_rise++;
            end
            if (vtun_en) begin
                vtun_hi++;
                if (vtun_first < 0) vtun_first = i;
            end
            if (dec_en) dec_hi++;
            if (!run && !prog) brk_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (err) begin
                err_cnt++;
                if (err_at < 0) err_at = i;
            end
            if (cmd_ready && done_at >= 0 && ready_at < 0) ready_at = i;
            if (pr && !run && run_fall_at < 0) run_fall_at = i;
            if (!pr && run && run_rise_at < 0) run_rise_at = i;
            if (!pp && prog && prog_rise_at < 0) prog_rise_at = i;
            if ((vinj_pulse && vtun_en) || (drain_sel !== vinj_pulse)) bad++;
            pv = vinj_pulse; pr = run; pp = prog;
            if (i == poke) cmd_valid = 1'b1;
            if (poke > 0 && i == poke + 2) cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0; n_mis = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_island = 2'd0;
        cmd_row = 6'd0; cmd_col = 6'd0; cmd_width = 16'd0; cmd_reps = 8'd0;
`ifdef FG_PROG_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_run", run, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_prog", prog, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err, vinj_pulse, vtun_en, dec_en}, 0);
        rst_n = 1'b1;

        // INJECT while in RUN mode is rejected
        issue(2'b00, 6'd3, 6'd5, 16'd10, 8'd2);
        watch(8, 0);
        chk("runmode_inj_err_at", err_at, 2);
        chk("runmode_inj_err_cnt", err_cnt, 1);
        chk("runmode_inj_vinj", vinj_hi, 0);
        chk("runmode_inj_dec", dec_hi, 0);
        chk("runmode_inj_done", done_cnt, 0);

        // PROG_MODE from RUN: break-before-make
        issue(2'b11, 6'd0, 6'd0, 16'd0, 8'd0);
        watch(12, 0);
        chk("prog_run_fall", run_fall_at, 2);
        chk("prog_prog_rise", prog_rise_at, 6);
        chk("prog_brk_cycles", brk_cnt, 4);
        chk("prog_done_at", done_at, 7);
        chk("prog_ready_at", ready_at, 8);

        // INJECT row 3 col 5 width 10 reps 2
        issue(2'b00, 6'd3, 6'd5, 16'd10, 8'd2);
        watch(40, 0);
        chk("inj_vinj_first", vinj_first, 6);
        chk("inj_vinj_last", vinj_last, 29);
        chk("inj_vinj_hi", vinj_hi, 20);
        chk("inj_vinj_rises", vinj_rise, 2);
        chk("inj_dec_hi", dec_hi, 32);
        chk("inj_row", row_seen, 3);
        chk("inj_col", col_seen, 5);
        chk("inj_done_at", done_at, 34);
        chk("inj_ready_at", ready_at, 35);
        chk("inj_excl", bad, 0);
        chk("inj_err", err_cnt, 0);
        chk("inj_addr_cleared", {row_addr, col_addr}, 0);

        // Illegal parameter rejects (prog mode active)
        issue(2'b00, 6'd3, 6'd26, 16'd10, 8'd2);
        watch(8, 0);
        chk("col26_err_at", err_at, 2);
        chk("col26_quiet", vinj_hi + dec_hi, 0);
        issue(2'b00, 6'd12, 6'd5, 16'd10, 8'd2);
        watch(8, 0);
        chk("row12_err_at", err_at, 2);
        issue(2'b00, 6'd11, 6'd25, 16'd0, 8'd2);
        watch(8, 0);
        chk("inj_w0_err_at", err_at, 2);
        issue(2'b00, 6'd11, 6'd25, 16'd5, 8'd0);
        watch(8, 0);
        chk("inj_r0_err_at", err_at, 2);
        issue(2'b01, 6'd0, 6'd0, 16'd0, 8'd0);
        watch(8, 0);
        chk("tun_w0_err_at", err_at, 2);

        // Largest legal address, single short pulse
        issue(2'b00, 6'd11, 6'd25, 16'd1, 8'd1);
        watch(16, 0);
        chk("edge_inj_vinj_hi", vinj_hi, 1);
        chk("edge_inj_done_at", done_at, 11);
        chk("edge_inj_err", err_cnt, 0);

        // TUNNEL width 7, with cmd_valid offered while busy
        issue(2'b01, 6'd0, 6'd0, 16'd7, 8'd0);
        watch(25, 3);
        chk("tun_first", vtun_first, 2);
        chk("tun_hi", vtun_hi, 7);
        chk("tun_vinj", vinj_hi, 0);
        chk("tun_dec", dec_hi, 0);
        chk("tun_done_at", done_at, 9);
        chk("tun_busy_ignored", done_cnt, 1);

        // PROG_MODE while already in prog mode: immediate done
        issue(2'b11, 6'd0, 6'd0, 16'd0, 8'd0);
        watch(6, 0);
        chk("prog_again_done_at", done_at, 2);
        chk("prog_again_brk", brk_cnt, 0);

        // Back to RUN mode
        issue(2'b10, 6'd0, 6'd0, 16'd0, 8'd0);
        watch(12, 0);
        chk("run_run_rise", run_rise_at, 6);
        chk("run_brk_cycles", brk_cnt, 4);
        chk("run_done_at", done_at, 7);

        // Re-enter prog mode, then reset during cycle 3 of a pulse
        issue(2'b11, 6'd0, 6'd0, 16'd0, 8'd0);
        watch(12, 0);
        chk("prog2_done_at", done_at, 7);
        issue(2'b00, 6'd1, 6'd2, 16'd10, 8'd1);
        repeat (7) @(negedge clk);
        chk("pre_rst_vinj", vinj_pulse, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vinj", vinj_pulse, 0);
        chk("async_rst_dec", dec_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_run", run, 1);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_prog", prog, 0);
        issue(2'b00, 6'd1, 6'd2, 16'd10, 8'd1);
        watch(8, 0);
        chk("post_rst_mode_run", err_at, 2);

`ifdef FG_PROG_ABORT_EN
        issue(2'b11, 6'd0, 6'd0, 16'd0, 8'd0);
        watch(12, 0);
        chk("abort_prog_done_at", done_at, 7);
        issue(2'b00, 6'd3, 6'd5, 16'd10, 8'd2);
        repeat (7) @(negedge clk);
        chk("abort_pre_vinj", vinj_pulse, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_vinj", vinj_pulse, 0);
        chk("abort_dec", dec_en, 0);
        chk("abort_done", done, 1);
        chk("abort_err", err, 1);
        @(negedge clk);
        chk("abort_done_clr", {done, err}, 0);
        chk("abort_ready", cmd_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
